gmii_frame_tx: RTL and testbench
================================

# gmii_frame_tx

Byte-stream-to-GMII Ethernet frame transmitter for the GbE readout path. Takes a payload stream (destination MAC onward) from the readout logic, prepends preamble/SFD, optionally pads to minimum size, appends the CRC-32 FCS, and enforces the inter-frame gap. Drives the `gmii_txd`/`gmii_tx_en`/`gmii_tx_er` inputs of a `gig_ethernet_pcs_pma_support_*` instance. Its clock is that instance's 125 MHz `userclk2_out`.

## Interface
- `IFG_BYTES`, default 12: idle cycles forced after each frame; legal range is ≥ 1.
- `PREAMBLE_BYTES`, default 7: count of 0x55 bytes before the SFD; legal range is ≥ 1.

Ports:
- `CLK` in 1: 125 MHz GMII transmit clock.
- `RST` in 1: synchronous, active-high reset.
- `S_TDATA` in 8: payload byte.
- `S_TVALID` in 1: payload byte valid.
- `S_TREADY` out 1: byte accepted when `S_TVALID & S_TREADY`.
- `S_TLAST` in 1: last payload byte of the frame.
- `S_TUSER` in 1: the byte is corrupt; it is sent with `GMII_TX_ER` set.
- `GMII_TXD` out 8: transmit data to the PCS/PMA.
- `GMII_TX_EN` out 1: transmit enable.
- `GMII_TX_ER` out 1: transmit error.
- `BUSY` out 1: high in every state except IDLE.
- `UNDERRUN` out 1: one-cycle pulse when a frame is aborted by underrun.
- `FRAME_CNT` out 16: count of frames completed with FCS. Wraps from 0xFFFF to 0.

## Operation
- FSM states: IDLE → PREAMBLE → SFD → DATA → [PAD] → FCS → IFG → IDLE.
- **IDLE:** when `S_TVALID` is sampled high, go to PREAMBLE. No data is consumed in IDLE.
- **PREAMBLE:** emit 0x55 for `PREAMBLE_BYTES` cycles.
- **SFD:** emit 0xD5 for 1 cycle.
- **DATA:** `S_TREADY` = 1, combinational from state.
  - Each accepted byte is emitted and fed to the CRC.
  - The 16-bit payload byte counter saturates at its maximum.
  - Accepting a byte with `S_TLAST` goes to PAD if padding is active and the count is < 60; otherwise it goes to FCS.
- **Underrun:** `S_TVALID` low while in DATA.
  - The output byte is 0x00 with `GMII_TX_EN` = 1 and `GMII_TX_ER` = 1 for that one cycle.
  - `UNDERRUN` pulses.
  - Next state is IFG; no FCS is sent and `FRAME_CNT` is unchanged.
- **PAD:** `S_TREADY` = 0. Emit 0x00 through the CRC until the payload count reaches 60.
- **FCS:** emit 4 bytes of the complemented CRC, least significant byte first.
  - `FRAME_CNT` increments on the 4th byte.
- **IFG:** `GMII_TX_EN` = 0 for `IFG_BYTES` cycles, then return to IDLE.
- **CRC-32 algorithm:**
  - Reflected polynomial 0xEDB88320.
  - Initial value 0xFFFFFFFF, reset in SFD.
  - Processed LSB-first, one byte per cycle.
- **`GMII_TX_ER`:** equals the registered `S_TUSER` for data bytes; 0 otherwise, except on underrun.
- **Outputs while not transmitting:** `GMII_TXD` = 0x00 whenever `GMII_TX_EN` = 0.
- **Reset values:** `GMII_TXD` = 0x00, `GMII_TX_EN` = 0, `GMII_TX_ER` = 0, `S_TREADY` = 0, `BUSY` = 0, `UNDERRUN` = 0, `FRAME_CNT` = 0. State = IDLE.
- **Reset mid-frame:** outputs drop to the reset values on the next edge. No FCS and no IFG are sent, and the partial frame is not counted.

## Timing
- The GMII outputs are registered: the byte chosen by the FSM at edge k appears on the pins after edge k+1.
- `S_TVALID` rises in IDLE at edge 0:
  - First 0x55 is on the pins after edge 2.
  - SFD is on the pins after edge `PREAMBLE_BYTES`+2.
  - `S_TREADY` rises in the cycle after the SFD decision. The first payload byte follows the SFD with no gap.
- A byte accepted at edge k appears on the pins after edge k+1. No bubbles occur while `S_TVALID` stays high.
- Frame length on the wire is `PREAMBLE_BYTES` + 1 + max(N, 60 if padding active) + 4 cycles of `GMII_TX_EN`. It is followed by exactly `IFG_BYTES` low cycles, then the IDLE decision cycle.
- Back-to-back frames: with `S_TVALID` held high, there are `IFG_BYTES`+1 cycles of `GMII_TX_EN` = 0 between frames.
- `UNDERRUN` is aligned with the TX_ER cycle on the pins.

## Configuration
- Macro: `GMII_TX_PAD_EN`.
- **Defined:** frames with fewer than 60 payload bytes are zero-padded to 60 before the FCS, and the FCS covers the padding.
- **Undefined:** the PAD state and comparator are removed; the FCS immediately follows the last payload byte regardless of length.

## Test plan
- **CRC check vector** (`GMII_TX_PAD_EN` undefined): send payload "123456789" (0x31..0x39) → 7×0x55, 0xD5, the 9 bytes, then FCS 0x26 0x39 0xF4 0xCB. `GMII_TX_EN` high for 21 cycles, then 12 low. `FRAME_CNT` = 1.
- **Padding** (`GMII_TX_PAD_EN` defined): send a 1-byte payload 0xAB with `S_TLAST` → 0xAB followed by 59×0x00, then 4 FCS bytes. `GMII_TX_EN` high for 72 cycles. `S_TREADY` high for exactly 1 cycle.
- **Back-to-back:** two 64-byte frames with `S_TVALID` held high → exactly 13 cycles of `GMII_TX_EN` = 0 between them. `FRAME_CNT` = 2.
- **Underrun:** drop `S_TVALID` after payload byte 10 → 1 cycle of `GMII_TX_ER` = 1 with `GMII_TXD` = 0x00, `UNDERRUN` pulses, no FCS, 12 idle cycles. `FRAME_CNT` unchanged.
- **Error propagation:** set `S_TUSER` on payload byte 5 → `GMII_TX_ER` is high only for that byte on the wire. The FCS is still sent and `FRAME_CNT` increments.
- **Reset mid-frame:** assert `RST` during DATA → on the next edge `GMII_TX_EN` = 0, `S_TREADY` = 0, `BUSY` = 0, `FRAME_CNT` = 0. A subsequent frame transmits correctly.

Source files
------------

// File: rtl/gmii_frame_tx.sv
// Byte-stream to GMII frame transmitter: preamble/SFD, optional minimum-size padding, CRC-32 FCS, inter-frame gap.
// Padding is built only when GMII_TX_PAD_EN is defined.
module gmii_frame_tx #(
  parameter int unsigned IFG_BYTES      = 12,
  parameter int unsigned PREAMBLE_BYTES = 7
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  S_TDATA,
  input  logic        S_TVALID,
  output logic        S_TREADY,
  input  logic        S_TLAST,
  input  logic        S_TUSER,
  output logic [7:0]  GMII_TXD,
  output logic        GMII_TX_EN,
  output logic        GMII_TX_ER,
  output logic        BUSY,
  output logic        UNDERRUN,
  output logic [15:0] FRAME_CNT
);

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
`ifdef GMII_TX_PAD_EN
    ST_PAD,
`endif
    ST_FCS,
    ST_IFG
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] gen_cnt_q, gen_cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] byte_cnt_inc;
  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_inv;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic        underrun_q, underrun_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        accept;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ({1'b0, r[31:1]} ^ CRC_POLY) : {1'b0, r[31:1]};
    return r;
  endfunction

  assign accept       = (state_q == ST_DATA) && S_TVALID;
  assign byte_cnt_inc = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 16'd1;
  assign crc_inv      = ~crc_q;

  assign S_TREADY   = (state_q == ST_DATA);
  assign BUSY       = (state_q != ST_IDLE);
  assign GMII_TXD   = txd_q;
  assign GMII_TX_EN = tx_en_q;
  assign GMII_TX_ER = tx_er_q;
  assign UNDERRUN   = underrun_q;
  assign FRAME_CNT  = frame_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      gen_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      crc_q       <= '1;
      txd_q       <= '0;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
      underrun_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gen_cnt_q   <= gen_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_q       <= crc_d;
      txd_q       <= txd_d;
      tx_en_q     <= tx_en_d;
      tx_er_q     <= tx_er_d;
      underrun_q  <= underrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (S_TVALID) state_d = ST_PREAMBLE;
      ST_PREAMBLE: if (gen_cnt_q == 16'(PREAMBLE_BYTES - 1)) state_d = ST_SFD;
      ST_SFD:      state_d = ST_DATA;
      ST_DATA: begin
        if (!S_TVALID) begin
          state_d = ST_IFG;
        end else if (S_TLAST) begin
`ifdef GMII_TX_PAD_EN
          state_d = (byte_cnt_inc < 16'd60) ? ST_PAD : ST_FCS;
`else
          state_d = ST_FCS;
`endif
        end
      end
`ifdef GMII_TX_PAD_EN
      ST_PAD:      if (byte_cnt_inc == 16'd60) state_d = ST_FCS;
`endif
      ST_FCS:      if (gen_cnt_q == 16'd3) state_d = ST_IFG;
      ST_IFG:      if (gen_cnt_q == 16'(IFG_BYTES - 1)) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    // gen_cnt restarts on every state change so each timed state counts from zero
    gen_cnt_d   = (state_d != state_q) ? '0 : gen_cnt_q + 16'd1;
    byte_cnt_d  = byte_cnt_q;
    crc_d       = crc_q;
    txd_d       = '0;
    tx_en_d     = 1'b0;
    tx_er_d     = 1'b0;
    underrun_d  = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_PREAMBLE: begin
        txd_d   = 8'h55;
        tx_en_d = 1'b1;
      end
      ST_SFD: begin
        txd_d      = 8'hD5;
        tx_en_d    = 1'b1;
        byte_cnt_d = '0;
        crc_d      = '1;
      end
      ST_DATA: begin
        tx_en_d = 1'b1;
        if (accept) begin
          txd_d      = S_TDATA;
          tx_er_d    = S_TUSER;
          byte_cnt_d = byte_cnt_inc;
          crc_d      = crc_byte(crc_q, S_TDATA);
        end else begin
          tx_er_d    = 1'b1;
          underrun_d = 1'b1;
        end
      end
`ifdef GMII_TX_PAD_EN
      ST_PAD: begin
        tx_en_d    = 1'b1;
        byte_cnt_d = byte_cnt_inc;
        crc_d      = crc_byte(crc_q, 8'h00);
      end
`endif
      ST_FCS: begin
        txd_d   = crc_inv[{gen_cnt_q[1:0], 3'b000} +: 8];
        tx_en_d = 1'b1;
        if (gen_cnt_q == 16'd3) frame_cnt_d = frame_cnt_q + 16'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gmii_frame_tx.sv
// Directed bench for gmii_frame_tx; expected frames, CRCs and timings are computed here.
// Padding expectations follow GMII_TX_PAD_EN.
module tb_gmii_frame_tx;
  localparam int unsigned PRE = 7;
  localparam int unsigned IFG = 12;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  S_TDATA = '0;
  logic        S_TVALID = 1'b0;
  logic        S_TREADY;
  logic        S_TLAST = 1'b0;
  logic        S_TUSER = 1'b0;
  logic [7:0]  GMII_TXD;
  logic        GMII_TX_EN;
  logic        GMII_TX_ER;
  logic        BUSY;
  logic        UNDERRUN;
  logic [15:0] FRAME_CNT;

  gmii_frame_tx #(.IFG_BYTES(IFG), .PREAMBLE_BYTES(PRE)) dut (
    .CLK(CLK), .RST(RST), .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TREADY(S_TREADY),
    .S_TLAST(S_TLAST), .S_TUSER(S_TUSER), .GMII_TXD(GMII_TXD), .GMII_TX_EN(GMII_TX_EN),
    .GMII_TX_ER(GMII_TX_ER), .BUSY(BUSY), .UNDERRUN(UNDERRUN), .FRAME_CNT(FRAME_CNT)
  );

  always #4 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [7:0] wire_q[$];
  logic       er_q[$];
  int         lens[$];
  int         gaps[$];
  logic [7:0] exp_q[$];
  logic [7:0] pay[0:127];
  int cur_len, low_cnt, idle_bad, un_cnt, un_bad, rdy_cnt;
  bit prev_en, seen_fall;

  always @(negedge CLK) begin
    if (GMII_TX_EN) begin
      if (!prev_en && seen_fall) gaps.push_back(low_cnt);
      cur_len++;
      wire_q.push_back(GMII_TXD);
      er_q.push_back(GMII_TX_ER);
    end else begin
      if (prev_en) begin
        lens.push_back(cur_len);
        cur_len = 0;
        low_cnt = 0;
        seen_fall = 1'b1;
      end
      low_cnt++;
      if (GMII_TXD !== 8'h00) idle_bad++;
    end
    prev_en = GMII_TX_EN;
    if (UNDERRUN) begin
      un_cnt++;
      if (!(GMII_TX_EN && GMII_TX_ER && GMII_TXD == 8'h00)) un_bad++;
    end
    if (S_TREADY) rdy_cnt++;
  end

  task automatic clear_mon();
    wire_q.delete(); er_q.delete(); lens.delete(); gaps.delete(); exp_q.delete();
    cur_len = 0; low_cnt = 0; idle_bad = 0; un_cnt = 0; un_bad = 0; rdy_cnt = 0;
    prev_en = 1'b0; seen_fall = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1; S_TVALID = 1'b0; S_TLAST = 1'b0; S_TUSER = 1'b0; S_TDATA = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    clear_mon();
  endtask

  // Appends the expected on-wire bytes of one frame built from pay[off +: n].
  task automatic build_exp(input int off, input int n);
    logic [7:0]  pl[$];
    logic [31:0] c;
    bit          fb;
    for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < n; i++) pl.push_back(pay[off + i]);
`ifdef GMII_TX_PAD_EN
    while (pl.size() < 60) pl.push_back(8'h00);
`endif
    c = 32'hFFFFFFFF;
    foreach (pl[k])
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ pl[k][b];
        c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
      end
    c = ~c;
    foreach (pl[k]) exp_q.push_back(pl[k]);
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
  endtask

  task automatic send_bytes(input int off, input int n, input bit last, input int tuser_idx);
    int t;
    for (int i = 0; i < n; i++) begin
      S_TVALID = 1'b1;
      S_TDATA  = pay[off + i];
      S_TLAST  = last && (i == n - 1);
      S_TUSER  = (i == tuser_idx);
      t = 0;
      @(negedge CLK);
      while (!S_TREADY && t < 500) begin
        @(negedge CLK);
        t++;
      end
      if (t >= 500) begin
        checks++; errors++;
        $display("FAIL ready_timeout: S_TREADY low for %0d cycles, required high within 500", t);
        return;
      end
      @(posedge CLK);
      #1;
    end
    S_TLAST = 1'b0;
    S_TUSER = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge CLK);
    while (BUSY && t < 1000) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 1000) begin
      checks++; errors++;
      $display("FAIL idle_timeout: BUSY still %0b after %0d cycles, required 0", BUSY, t);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (GMII_TXD !== 8'h00) begin errors++; $display("FAIL rst_txd: got %02h expected 00", GMII_TXD); end
    checks++; if (GMII_TX_EN !== 1'b0) begin errors++; $display("FAIL rst_en: got %0b expected 0", GMII_TX_EN); end
    checks++; if (GMII_TX_ER !== 1'b0) begin errors++; $display("FAIL rst_er: got %0b expected 0", GMII_TX_ER); end
    checks++; if (S_TREADY !== 1'b0) begin errors++; $display("FAIL rst_tready: got %0b expected 0", S_TREADY); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", BUSY); end
    checks++; if (UNDERRUN !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %0b expected 0", UNDERRUN); end
    checks++; if (FRAME_CNT !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d expected 0", FRAME_CNT); end
    @(posedge CLK);
    #1 RST = 1'b0;
    clear_mon();
  endtask

  task automatic test_crc_vector();
    int er_hi;
    do_reset();
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
`ifdef GMII_TX_PAD_EN
    build_exp(0, 9);
`else
    for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 9; i++) exp_q.push_back(8'h31 + 8'(i));
    exp_q.push_back(8'h26); exp_q.push_back(8'h39); exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
`endif
    send_bytes(0, 9, 1'b1, -1);
    S_TVALID = 1'b0;
    wait_idle();
    checks++;
    if (wire_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL crc_len: got %0d bytes with TX_EN, expected %0d", wire_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wire_q.size(); i++) begin
      checks++;
      if (wire_q[i] !== exp_q[i]) begin errors++; $display("FAIL crc_byte[%0d]: got %02h expected %02h", i, wire_q[i], exp_q[i]); end
    end
    er_hi = 0;
    foreach (er_q[i]) if (er_q[i]) er_hi++;
    checks++; if (er_hi != 0) begin errors++; $display("FAIL crc_er: got %0d TX_ER cycles expected 0", er_hi); end
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL crc_idle_txd: got %0d nonzero idle bytes expected 0", idle_bad); end
    checks++; if (FRAME_CNT !== 16'd1) begin errors++; $display("FAIL crc_frame_cnt: got %0d expected 1", FRAME_CNT); end
  endtask

  task automatic test_padding();
    int exp_len;
    do_reset();
    pay[0] = 8'hAB;
    build_exp(0, 1);
`ifdef GMII_TX_PAD_EN
    exp_len = 72;
`else
    exp_len = 13;
`endif
    send_bytes(0, 1, 1'b1, -1);
    S_TVALID = 1'b0;
    wait_idle();
    checks++;
    if (lens.size() != 1 || lens[0] != exp_len) begin
      errors++; $display("FAIL pad_len: got %0d frames, first %0d cycles, expected 1 of %0d", lens.size(), (lens.size() > 0) ? lens[0] : -1, exp_len);
    end
    for (int i = 0; i < exp_q.size() && i < wire_q.size(); i++) begin
      checks++;
      if (wire_q[i] !== exp_q[i]) begin errors++; $display("FAIL pad_byte[%0d]: got %02h expected %02h", i, wire_q[i], exp_q[i]); end
    end
    checks++; if (rdy_cnt != 1) begin errors++; $display("FAIL pad_tready: got %0d ready cycles expected 1", rdy_cnt); end
    checks++; if (FRAME_CNT !== 16'd1) begin errors++; $display("FAIL pad_frame_cnt: got %0d expected 1", FRAME_CNT); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      pay[i]      = 8'(i);
      pay[64 + i] = 8'hA0 ^ 8'(i);
    end
    build_exp(0, 64);
    build_exp(64, 64);
    send_bytes(0, 64, 1'b1, -1);
    send_bytes(64, 64, 1'b1, -1);
    S_TVALID = 1'b0;
    wait_idle();
    checks++;
    if (lens.size() != 2 || lens[0] != 76 || lens[1] != 76) begin
      errors++; $display("FAIL b2b_lens: got %0d frames (%0d, %0d) expected 2 of 76", lens.size(),
                         (lens.size() > 0) ? lens[0] : -1, (lens.size() > 1) ? lens[1] : -1);
    end
    checks++;
    if (gaps.size() != 1 || gaps[0] != IFG + 1) begin
      errors++; $display("FAIL b2b_gap: got %0d gaps, first %0d cycles, expected 1 of %0d", gaps.size(), (gaps.size() > 0) ? gaps[0] : -1, IFG + 1);
    end
    checks++;
    if (wire_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL b2b_bytes: got %0d bytes expected %0d", wire_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wire_q.size(); i++) begin
      checks++;
      if (wire_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte[%0d]: got %02h expected %02h", i, wire_q[i], exp_q[i]); end
    end
    checks++; if (FRAME_CNT !== 16'd2) begin errors++; $display("FAIL b2b_frame_cnt: got %0d expected 2", FRAME_CNT); end
  endtask

  task automatic test_underrun();
    logic [15:0] fc;
    int t, busy_cycles, er_hi;
    fc = FRAME_CNT;
    clear_mon();
    for (int i = 0; i < 10; i++) pay[i] = 8'hC0 + 8'(i);
    for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 10; i++) exp_q.push_back(pay[i]);
    exp_q.push_back(8'h00);
    send_bytes(0, 10, 1'b0, -1);
    S_TVALID = 1'b0;
    t = 0;
    @(negedge CLK);
    while (!UNDERRUN && t < 50) begin @(negedge CLK); t++; end
    checks++; if (t >= 50) begin errors++; $display("FAIL un_pulse: UNDERRUN not seen within %0d cycles", t); end
    busy_cycles = 0;
    while (BUSY && busy_cycles < 100) begin busy_cycles++; @(negedge CLK); end
    checks++; if (busy_cycles != IFG) begin errors++; $display("FAIL un_ifg: got %0d busy cycles from pulse, expected %0d", busy_cycles, IFG); end
    wait_idle();
    checks++; if (un_cnt != 1) begin errors++; $display("FAIL un_count: got %0d pulses expected 1", un_cnt); end
    checks++; if (un_bad != 0) begin errors++; $display("FAIL un_align: got %0d misaligned pulses expected 0", un_bad); end
    checks++;
    if (lens.size() != 1 || lens[0] != PRE + 1 + 11) begin
      errors++; $display("FAIL un_len: got %0d frames, first %0d cycles, expected 1 of %0d", lens.size(), (lens.size() > 0) ? lens[0] : -1, PRE + 12);
    end
    for (int i = 0; i < exp_q.size() && i < wire_q.size(); i++) begin
      checks++;
      if (wire_q[i] !== exp_q[i]) begin errors++; $display("FAIL un_byte[%0d]: got %02h expected %02h", i, wire_q[i], exp_q[i]); end
    end
    er_hi = 0;
    foreach (er_q[i]) if (er_q[i]) er_hi++;
    checks++;
    if (er_hi != 1 || er_q.size() == 0 || er_q[er_q.size() - 1] !== 1'b1) begin
      errors++; $display("FAIL un_er: got %0d TX_ER cycles, expected 1 on the final byte", er_hi);
    end
    checks++; if (FRAME_CNT !== fc) begin errors++; $display("FAIL un_frame_cnt: got %0d expected %0d", FRAME_CNT, fc); end
  endtask

  task automatic test_error_prop();
    logic [15:0] fc;
    int er_hi;
    fc = FRAME_CNT;
    clear_mon();
    for (int i = 0; i < 60; i++) pay[i] = 8'(i * 7 + 3);
    build_exp(0, 60);
    send_bytes(0, 60, 1'b1, 4);
    S_TVALID = 1'b0;
    wait_idle();
    er_hi = 0;
    foreach (er_q[i]) if (er_q[i]) er_hi++;
    checks++;
    if (er_hi != 1 || er_q.size() <= PRE + 5 || er_q[PRE + 5] !== 1'b1) begin
      errors++; $display("FAIL err_er: got %0d TX_ER cycles, expected 1 at wire byte %0d", er_hi, PRE + 5);
    end
    checks++;
    if (wire_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL err_bytes: got %0d bytes expected %0d", wire_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wire_q.size(); i++) begin
      checks++;
      if (wire_q[i] !== exp_q[i]) begin errors++; $display("FAIL err_byte[%0d]: got %02h expected %02h", i, wire_q[i], exp_q[i]); end
    end
    checks++; if (FRAME_CNT !== fc + 16'd1) begin errors++; $display("FAIL err_frame_cnt: got %0d expected %0d", FRAME_CNT, fc + 16'd1); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) pay[i] = 8'h5A ^ 8'(i);
    send_bytes(0, 5, 1'b0, -1);
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL mid_pre_busy: got %0b expected 1", BUSY); end
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checks++; if (GMII_TX_EN !== 1'b0) begin errors++; $display("FAIL mid_en: got %0b expected 0", GMII_TX_EN); end
    checks++; if (S_TREADY !== 1'b0) begin errors++; $display("FAIL mid_tready: got %0b expected 0", S_TREADY); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b expected 0", BUSY); end
    checks++; if (FRAME_CNT !== 16'd0) begin errors++; $display("FAIL mid_frame_cnt: got %0d expected 0", FRAME_CNT); end
    @(posedge CLK);
    #1 RST = 1'b0;
    S_TVALID = 1'b0;
    clear_mon();
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    build_exp(0, 9);
    send_bytes(0, 9, 1'b1, -1);
    S_TVALID = 1'b0;
    wait_idle();
    checks++;
    if (wire_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL mid_next_len: got %0d bytes expected %0d", wire_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wire_q.size(); i++) begin
      checks++;
      if (wire_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_next_byte[%0d]: got %02h expected %02h", i, wire_q[i], exp_q[i]); end
    end
    checks++; if (FRAME_CNT !== 16'd1) begin errors++; $display("FAIL mid_next_frame_cnt: got %0d expected 1", FRAME_CNT); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_crc_vector();
    test_padding();
    test_back_to_back();
    test_underrun();
    test_error_prop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
